// File: rtl/retire_maptable_pkg.sv
// retire_maptable_pkg
//   Shared integer-rename sizing constants, the retire map table FSM state
//   enum and a small width helper. Imported by every retire_maptable file.
package retire_maptable_pkg;

  localparam int ARF_INT_SIZE       = 32;
  localparam int PRF_INT_INDEX_SIZE = 6;
  localparam int RENAME_WIDTH       = 4;
  localparam int ARCH_REG_W         = 5;

  typedef enum logic [0:0] {
    RM_IDLE,
    RM_RESTORE
  } retire_maptable_state_t;

  // Index width for n items, never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/retire_maptable_if.sv
// retire_maptable_if
//   Bundles the retire map table's commit, freelist-release and restore buses.
//   master : the ROB / front-end side (drives commits, flush, restore_ready)
//   slave  : the retire map table itself
//   Signals:
//     commit_valid/commit_rd_valid/commit_rd/commit_prd  in-order commit group
//     commit_ready                                        group accepted
//     free_valid/free_prf                                 registered releases
//     flush                                               start a restore
//     restore_valid/restore_ready/restore_idx/restore_map beat stream
//     restore_done                                        pulse after last beat
interface retire_maptable_if
  import retire_maptable_pkg::*;
#(
  parameter int COMMIT_WIDTH  = RENAME_WIDTH,
  parameter int ARF_SIZE      = ARF_INT_SIZE,
  parameter int PRF_IDX_W     = PRF_INT_INDEX_SIZE,
  parameter int RESTORE_WIDTH = 4
) ();

  localparam int IDX_W = idxWidth(ARF_SIZE / RESTORE_WIDTH);

  logic [COMMIT_WIDTH-1:0]                 commit_valid;
  logic [COMMIT_WIDTH-1:0]                 commit_rd_valid;
  logic [COMMIT_WIDTH-1:0][ARCH_REG_W-1:0] commit_rd;
  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0]  commit_prd;
  logic                                    commit_ready;
  logic [COMMIT_WIDTH-1:0]                 free_valid;
  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0]  free_prf;
  logic                                    flush;
  logic                                    restore_valid;
  logic                                    restore_ready;
  logic [IDX_W-1:0]                        restore_idx;
  logic [RESTORE_WIDTH-1:0][PRF_IDX_W-1:0] restore_map;
  logic                                    restore_done;

  modport master (
    output commit_valid, commit_rd_valid, commit_rd, commit_prd, flush,
           restore_ready,
    input  commit_ready, free_valid, free_prf, restore_valid, restore_idx,
           restore_map, restore_done
  );

  modport slave (
    input  commit_valid, commit_rd_valid, commit_rd, commit_prd, flush,
           restore_ready,
    output commit_ready, free_valid, free_prf, restore_valid, restore_idx,
           restore_map, restore_done
  );

endinterface

// File: rtl/retire_group_resolve.sv
// retire_group_resolve
//   Combinational same-rd resolution inside one commit group.
//   Inputs : commit_valid_i, rd_valid_i, rd_i, prd_i (per slot), map_i (the
//            registered committed map)
//   Outputs: accepted_o   slots in the contiguous valid run from slot 0
//            free_valid_o slot releases a physical register
//            free_prf_o   released index (0 when not releasing)
//            map_we_o     slot is the last accepted writer of its rd
module retire_group_resolve
  import retire_maptable_pkg::*;
#(
  parameter int COMMIT_WIDTH = RENAME_WIDTH,
  parameter int ARF_SIZE     = ARF_INT_SIZE,
  parameter int PRF_IDX_W    = PRF_INT_INDEX_SIZE
) (
  input  logic [COMMIT_WIDTH-1:0]                 commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0]                 rd_valid_i,
  input  logic [COMMIT_WIDTH-1:0][ARCH_REG_W-1:0] rd_i,
  input  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0]  prd_i,
  input  logic [ARF_SIZE-1:0][PRF_IDX_W-1:0]      map_i,
  output logic [COMMIT_WIDTH-1:0]                 accepted_o,
  output logic [COMMIT_WIDTH-1:0]                 free_valid_o,
  output logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0]  free_prf_o,
  output logic [COMMIT_WIDTH-1:0]                 map_we_o
);

  localparam int MAP_W = idxWidth(ARF_SIZE);

  logic                                   run;
  logic [COMMIT_WIDTH-1:0]                accepted;
  logic [COMMIT_WIDTH-1:0]                freeValid;
  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0] freePrf;
  logic [COMMIT_WIDTH-1:0]                mapWe;

  // A slot counts only while every earlier slot is valid. An older slot with
  // the same rd supplies the freed register (the ascending scan leaves the
  // nearest one), and only the youngest writer of an rd updates the map.
  always_comb begin
    run       = 1'b1;
    accepted  = '0;
    freeValid = '0;
    freePrf   = '0;
    mapWe     = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      run         = run & commit_valid_i[i];
      accepted[i] = run;
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (accepted[i] && rd_valid_i[i]) begin
        freeValid[i] = 1'b1;
        if (rd_i[i] == '0) begin
          freePrf[i] = prd_i[i];
        end else begin
          freePrf[i] = map_i[MAP_W'(rd_i[i])];
          for (int j = 0; j < i; j++) begin
            if (accepted[j] && rd_valid_i[j] && (rd_i[j] == rd_i[i])) begin
              freePrf[i] = prd_i[j];
            end
          end
          mapWe[i] = 1'b1;
          for (int k = i + 1; k < COMMIT_WIDTH; k++) begin
            if (accepted[k] && rd_valid_i[k] && (rd_i[k] == rd_i[i])) begin
              mapWe[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  assign accepted_o   = accepted;
  assign free_valid_o = freeValid;
  assign free_prf_o   = freePrf;
  assign map_we_o     = mapWe;

endmodule

// File: rtl/retire_maptable.sv
// retire_maptable
//   Committed architectural-to-physical register map at the retire end of
//   integer renaming. Accepts in-order commit groups, releases superseded
//   physical registers to the freelist and, on flush, streams the committed
//   map back to the front end in RESTORE_WIDTH-entry beats.
//   Ports:
//     clock, reset      system clock, synchronous active-high reset
//     rmBus (slave)     commit / free / flush / restore buses
//     perf_commit_cnt   (RETIRE_MAPTABLE_PERF_EN only) accepted slots, wraps
//     perf_restore_cnt  (RETIRE_MAPTABLE_PERF_EN only) completed restores
//   Optional feature macro: RETIRE_MAPTABLE_PERF_EN
//   ARF_SIZE must be a multiple of RESTORE_WIDTH.
module retire_maptable
  import retire_maptable_pkg::*;
#(
  parameter int COMMIT_WIDTH  = RENAME_WIDTH,
  parameter int ARF_SIZE      = ARF_INT_SIZE,
  parameter int PRF_IDX_W     = PRF_INT_INDEX_SIZE,
  parameter int RESTORE_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  retire_maptable_if.slave     rmBus
`ifdef RETIRE_MAPTABLE_PERF_EN
  ,
  output logic [31:0]          perf_commit_cnt,
  output logic [15:0]          perf_restore_cnt
`endif
);

  localparam int BEATS = ARF_SIZE / RESTORE_WIDTH;
  localparam int IDX_W = idxWidth(BEATS);
  localparam int MAP_W = idxWidth(ARF_SIZE);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  retire_maptable_state_t                 state_q, state_d;
  logic [IDX_W-1:0]                       beat_q, beat_d;
  logic                                   done_q, done_d;
  logic [ARF_SIZE-1:0][PRF_IDX_W-1:0]     map_q, map_d;
  logic [COMMIT_WIDTH-1:0]                freeValid_q, freeValid_d;
  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0] freePrf_q, freePrf_d;

  logic                                   commitReady;
  logic [COMMIT_WIDTH-1:0]                accepted;
  logic [COMMIT_WIDTH-1:0]                slotFreeValid;
  logic [COMMIT_WIDTH-1:0][PRF_IDX_W-1:0] slotFreePrf;
  logic [COMMIT_WIDTH-1:0]                mapWe;
  logic [MAP_W-1:0]                       entry;

  retire_group_resolve #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .ARF_SIZE     (ARF_SIZE),
    .PRF_IDX_W    (PRF_IDX_W)
  ) uResolve (
    .commit_valid_i (rmBus.commit_valid),
    .rd_valid_i     (rmBus.commit_rd_valid),
    .rd_i           (rmBus.commit_rd),
    .prd_i          (rmBus.commit_prd),
    .map_i          (map_q),
    .accepted_o     (accepted),
    .free_valid_o   (slotFreeValid),
    .free_prf_o     (slotFreePrf),
    .map_we_o       (mapWe)
  );

  // Commits are taken only in IDLE, so ready depends on state alone.
  assign commitReady = (state_q == RM_IDLE);

  // Next state: flush always (re)starts at beat 0; otherwise a handshake on
  // the last beat finishes the restore and schedules the done pulse.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    case (state_q)
      RM_IDLE: begin
        if (rmBus.flush) begin
          state_d = RM_RESTORE;
          beat_d  = '0;
        end
      end
      RM_RESTORE: begin
        if (rmBus.flush) begin
          beat_d = '0;
        end else if (rmBus.restore_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = RM_IDLE;
            beat_d  = '0;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RM_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Map writes and freelist releases from the accepted group; release
  // strobes are cleared in any cycle without an accepted group.
  always_comb begin
    map_d       = map_q;
    freeValid_d = '0;
    freePrf_d   = '0;
    if (commitReady) begin
      freeValid_d = slotFreeValid;
      freePrf_d   = slotFreePrf;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (mapWe[i]) begin
          map_d[MAP_W'(rmBus.commit_rd[i])] = rmBus.commit_prd[i];
        end
      end
    end
  end

  // State, map and release registers; reset restores the identity map.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RM_IDLE;
      beat_q      <= '0;
      done_q      <= 1'b0;
      freeValid_q <= '0;
      freePrf_q   <= '0;
      for (int i = 0; i < ARF_SIZE; i++) begin
        map_q[i] <= PRF_IDX_W'(i);
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      freeValid_q <= freeValid_d;
      freePrf_q   <= freePrf_d;
      map_q       <= map_d;
    end
  end

  // Restore data is read straight from the registered map; forced to zero
  // outside RESTORE so the bus is quiet when idle.
  always_comb begin
    entry             = '0;
    rmBus.restore_map = '0;
    if (state_q == RM_RESTORE) begin
      for (int k = 0; k < RESTORE_WIDTH; k++) begin
        entry                = MAP_W'(int'(beat_q) * RESTORE_WIDTH + k);
        rmBus.restore_map[k] = map_q[entry];
      end
    end
  end

  assign rmBus.commit_ready  = commitReady;
  assign rmBus.free_valid    = freeValid_q;
  assign rmBus.free_prf      = freePrf_q;
  assign rmBus.restore_valid = (state_q == RM_RESTORE);
  assign rmBus.restore_idx   = beat_q;
  assign rmBus.restore_done  = done_q;

`ifdef RETIRE_MAPTABLE_PERF_EN
  logic [31:0] commitCnt_q;
  logic [15:0] restoreCnt_q;

  // Counts accepted slots per cycle and completed restores; both wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      commitCnt_q  <= '0;
      restoreCnt_q <= '0;
    end else begin
      if (commitReady) begin
        commitCnt_q <= commitCnt_q + 32'($countones(accepted));
      end
      if (done_d) begin
        restoreCnt_q <= restoreCnt_q + 16'd1;
      end
    end
  end

  assign perf_commit_cnt  = commitCnt_q;
  assign perf_restore_cnt = restoreCnt_q;
`endif

endmodule

// File: tb/tb_retire_maptable.sv
// tb_retire_maptable
//   Directed, table-driven bench for retire_maptable: a table of commit
//   groups with hand-computed releases, then hand-written restore sequences
//   (full restore, stall and restart, reset mid-restore).
module tb_retire_maptable;
  import retire_maptable_pkg::*;

  typedef struct {
    string           name;
    logic [3:0]      valid;
    logic [3:0]      rdValid;
    logic [3:0][4:0] rd;
    logic [3:0][5:0] prd;
    logic [3:0]      expFreeValid;
    logic [3:0][5:0] expFreePrf;
  } vec_t;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;
  logic [5:0] expMap [32];
  vec_t vecs [7];

  retire_maptable_if bus ();

  retire_maptable dut (
    .clock (clock),
    .reset (reset),
    .rmBus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n, input logic [3:0] v, input logic [3:0] rv,
                              input logic [4:0] r3, input logic [4:0] r2,
                              input logic [4:0] r1, input logic [4:0] r0,
                              input logic [5:0] p3, input logic [5:0] p2,
                              input logic [5:0] p1, input logic [5:0] p0,
                              input logic [3:0] efv,
                              input logic [5:0] e3, input logic [5:0] e2,
                              input logic [5:0] e1, input logic [5:0] e0);
    vec_t t;
    t.name = n; t.valid = v; t.rdValid = rv;
    t.rd = {r3, r2, r1, r0};
    t.prd = {p3, p2, p1, p0};
    t.expFreeValid = efv;
    t.expFreePrf = {e3, e2, e1, e0};
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    bus.commit_valid    = t.valid;
    bus.commit_rd_valid = t.rdValid;
    bus.commit_rd       = t.rd;
    bus.commit_prd      = t.prd;
  endtask

  task automatic clearCommit();
    bus.commit_valid    = '0;
    bus.commit_rd_valid = '0;
    bus.commit_rd       = '0;
    bus.commit_prd      = '0;
  endtask

  task automatic checkBeat(input int b, input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.restore_valid), 32'd1);
    checkOutput({tag, "_idx"}, 32'(bus.restore_idx), 32'(b));
    checkOutput({tag, "_cready"}, 32'(bus.commit_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s_b%0d_e%0d", tag, b, k),
                  32'(bus.restore_map[k]), 32'(expMap[b*4+k]));
    end
  endtask

  // Runs the remaining beats from 'first' with restore_ready high, then
  // checks the done pulse and that it lasts a single cycle.
  task automatic runBeats(input int first, input string tag);
    bus.restore_ready = 1'b1;
    for (int b = first; b < 8; b++) begin
      checkBeat(b, tag);
      @(negedge clock);
    end
    checkOutput({tag, "_done"}, 32'(bus.restore_done), 32'd1);
    checkOutput({tag, "_validEnd"}, 32'(bus.restore_valid), 32'd0);
    checkOutput({tag, "_creadyEnd"}, 32'(bus.commit_ready), 32'd1);
    @(negedge clock);
    checkOutput({tag, "_donePulse"}, 32'(bus.restore_done), 32'd0);
  endtask

  initial begin
    int eb;
    assertCount = 0;
    failCount   = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.restore_ready = 1'b0;
    clearCommit();
    for (int i = 0; i < 32; i++) expMap[i] = 6'(i);

    //               name      valid    rdv      rd3..rd0         prd3..prd0          efv      efree3..0
    vecs[0] = mk("single", 4'b0001, 4'b0001, 0, 0, 0, 5,   0, 0, 0, 40,    4'b0001, 0, 0, 0, 5);
    vecs[1] = mk("samerd", 4'b0011, 4'b0011, 0, 0, 3, 3,   0, 0, 34, 33,   4'b0011, 0, 0, 33, 3);
    vecs[2] = mk("rd0gap", 4'b1101, 4'b1111, 9, 8, 4, 0,   52, 51, 49, 50, 4'b0001, 0, 0, 0, 50);
    vecs[3] = mk("mixed",  4'b1111, 4'b1011, 5, 2, 5, 7,   47, 61, 46, 45, 4'b1011, 46, 0, 40, 7);
    vecs[4] = mk("idle",   4'b0000, 4'b0000, 0, 0, 0, 0,   0, 0, 0, 0,     4'b0000, 0, 0, 0, 0);
    vecs[5] = mk("triple", 4'b1111, 4'b1111, 0, 10, 10, 10, 23, 22, 21, 20, 4'b1111, 23, 21, 20, 10);
    vecs[6] = mk("nordv",  4'b1111, 4'b0000, 1, 2, 3, 4,   11, 12, 13, 14, 4'b0000, 0, 0, 0, 0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("[TB] reset state");
    checkOutput("rst_cready", 32'(bus.commit_ready), 32'd1);
    checkOutput("rst_rvalid", 32'(bus.restore_valid), 32'd0);
    checkOutput("rst_done", 32'(bus.restore_done), 32'd0);
    checkOutput("rst_fvalid", 32'(bus.free_valid), 32'd0);
    checkOutput("rst_idx", 32'(bus.restore_idx), 32'd0);
    checkOutput("rst_map", 32'(bus.restore_map), 32'd0);

    $display("[TB] commit vector table");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
      @(negedge clock);
      checkOutput({vecs[v].name, "_fvalid"}, 32'(bus.free_valid), 32'(vecs[v].expFreeValid));
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("%s_fprf%0d", vecs[v].name, k),
                    32'(bus.free_prf[k]), 32'(vecs[v].expFreePrf[k]));
      end
    end
    clearCommit();
    @(negedge clock);
    checkOutput("cleared_fvalid", 32'(bus.free_valid), 32'd0);
    expMap[3] = 6'd34; expMap[5] = 6'd47; expMap[7] = 6'd45; expMap[10] = 6'd22;

    $display("[TB] full restore with same-cycle commit");
    bus.flush = 1'b1;
    bus.restore_ready = 1'b1;
    applyStimulus(mk("fc", 4'b0001, 4'b0001, 0, 0, 0, 12, 0, 0, 0, 55, 4'b0001, 0, 0, 0, 12));
    @(negedge clock);
    bus.flush = 1'b0;
    clearCommit();
    expMap[12] = 6'd55;
    checkOutput("fc_fvalid", 32'(bus.free_valid), 32'd1);
    checkOutput("fc_fprf0", 32'(bus.free_prf[0]), 32'd12);
    for (int b = 0; b < 2; b++) begin
      checkBeat(b, "full");
      @(negedge clock);
    end
    // Commit offered while restoring must be ignored.
    applyStimulus(mk("blk", 4'b0001, 4'b0001, 0, 0, 0, 1, 0, 0, 0, 63, 4'b0001, 0, 0, 0, 1));
    checkBeat(2, "full");
    @(negedge clock);
    clearCommit();
    checkOutput("blk_fvalid", 32'(bus.free_valid), 32'd0);
    runBeats(3, "full");

    $display("[TB] stalled restore and flush restart");
    bus.flush = 1'b1;
    bus.restore_ready = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    checkBeat(0, "stall");
    @(negedge clock);
    checkBeat(0, "stallHold");
    eb = 0;
    for (int c = 0; c < 16 && eb < 4; c++) begin
      bus.restore_ready = (c % 2 == 0);
      @(negedge clock);
      if (c % 2 == 0) eb++;
      checkBeat(eb, "toggle");
    end
    bus.flush = 1'b1;
    bus.restore_ready = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    runBeats(0, "restart");

    $display("[TB] reset during restore");
    bus.flush = 1'b1;
    bus.restore_ready = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checkBeat(b, "abort");
      if (b < 3) @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_rvalid", 32'(bus.restore_valid), 32'd0);
    checkOutput("abort_cready", 32'(bus.commit_ready), 32'd1);
    checkOutput("abort_done", 32'(bus.restore_done), 32'd0);
    checkOutput("abort_idx", 32'(bus.restore_idx), 32'd0);
    @(negedge clock);
    checkOutput("abort_doneLate", 32'(bus.restore_done), 32'd0);
    for (int i = 0; i < 32; i++) expMap[i] = 6'(i);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    runBeats(0, "ident");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
